// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues word fetches over valid/ready with a pulsed
// response, and buffers instructions into IF/ID. Optional macro IF_PERF_CNT_EN adds perf counters.
module if_fetch_unit #(
    parameter logic [29:0] RESET_PC    = 30'h0000_0C00,
    parameter logic [7:0]  RSP_TIMEOUT = 8'd64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] npc,
    input  logic        pc_wr,
    input  logic        redirect,
    output logic [29:0] pc,
    output logic        imem_req_valid,
    output logic [29:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        id_stall,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [29:0] ifid_pc,
    output logic        fetch_err
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch,
    output logic [31:0] perf_drop
`endif
);

    // state  | meaning
    // S_REQ  | request valid, waiting for the memory to accept it
    // S_WAIT | one fetch outstanding, timeout timer running
    // S_HOLD | response parked in skid because IF/ID was full and stalled
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_req_valid;
    logic [29:0] r_pc;
    logic        r_drop;
    logic [31:0] r_skid_data;
    logic        r_ifid_valid;
    logic [31:0] r_ifid_instr;
    logic [29:0] r_ifid_pc;
    logic        r_fetch_err;
    logic [7:0]  r_tmr;

    logic        w_accept;
    logic        w_consume;
    logic        w_can_load;
    logic        w_load;
    logic [31:0] w_load_data;

    assign w_accept    = r_req_valid && imem_req_ready;
    assign w_consume   = r_ifid_valid && !id_stall;
    assign w_can_load  = !r_ifid_valid || w_consume;
    assign w_load      = !redirect && w_can_load &&
                         ((r_state == S_WAIT && imem_rsp_valid && !r_drop) || r_state == S_HOLD);
    assign w_load_data = (r_state == S_HOLD) ? r_skid_data : imem_rsp_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_REQ;
            r_req_valid  <= 1'b1;
            r_pc         <= RESET_PC;
            r_drop       <= 1'b0;
            r_skid_data  <= '0;
            r_ifid_valid <= 1'b0;
            r_ifid_instr <= '0;
            r_ifid_pc    <= '0;
        end else if (redirect) begin
            // Flush everything; an in-flight fetch must be swallowed when it returns.
            r_pc         <= npc;
            r_ifid_valid <= 1'b0;
            r_skid_data  <= '0;
            case (r_state)
                S_REQ: begin
                    if (w_accept) begin
                        r_state     <= S_WAIT;
                        r_req_valid <= 1'b0;
                        r_drop      <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        r_state     <= S_REQ;
                        r_req_valid <= 1'b1;
                        r_drop      <= 1'b0;
                    end else begin
                        r_drop <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_REQ;
                    r_req_valid <= 1'b1;
                    r_drop      <= 1'b0;
                end
            endcase
        end else begin
            if (w_consume) begin
                r_ifid_valid <= 1'b0;
            end
            if (w_load) begin
                r_ifid_valid <= 1'b1;
                r_ifid_instr <= w_load_data;
                r_ifid_pc    <= r_pc;
                if (pc_wr) begin
                    r_pc <= npc;
                end
            end
            case (r_state)
                S_REQ: begin
                    if (w_accept) begin
                        r_state     <= S_WAIT;
                        r_req_valid <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (r_drop || w_can_load) begin
                            r_state     <= S_REQ;
                            r_req_valid <= 1'b1;
                            r_drop      <= 1'b0;
                        end else begin
                            r_skid_data <= imem_rsp_data;
                            r_state     <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (w_can_load) begin
                        r_state     <= S_REQ;
                        r_req_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_REQ;
                    r_req_valid <= 1'b1;
                    r_drop      <= 1'b0;
                end
            endcase
        end
    end

    // Down-counter loaded at accept; hitting zero while still waiting flags a lost response.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmr       <= '0;
            r_fetch_err <= 1'b0;
        end else if (w_accept) begin
            r_tmr <= RSP_TIMEOUT - 8'd1;
        end else if (r_state == S_WAIT && !imem_rsp_valid) begin
            if (r_tmr == 8'd0) begin
                r_fetch_err <= 1'b1;
            end else begin
                r_tmr <= r_tmr - 8'd1;
            end
        end
    end

`ifdef IF_PERF_CNT_EN
    logic        w_discard;
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_drop;

    // A flushed skid entry is a response that never reached ID, so it counts as dropped.
    assign w_discard = (r_state == S_WAIT && imem_rsp_valid && (r_drop || redirect)) ||
                       (r_state == S_HOLD && redirect);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_fetch <= '0;
            r_perf_drop  <= '0;
        end else begin
            if (w_load) begin
                r_perf_fetch <= r_perf_fetch + 32'd1;
            end
            if (w_discard) begin
                r_perf_drop <= r_perf_drop + 32'd1;
            end
        end
    end

    assign perf_fetch = r_perf_fetch;
    assign perf_drop  = r_perf_drop;
`endif

    assign pc             = r_pc;
    assign imem_req_valid = r_req_valid;
    assign imem_req_addr  = r_pc;
    assign ifid_valid     = r_ifid_valid;
    assign ifid_instr     = r_ifid_instr;
    assign ifid_pc        = r_ifid_pc;
    assign fetch_err      = r_fetch_err;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: simple memory model returning the word address as data.
module tb_if_fetch_unit;

    logic        clk;
    logic        rst;
    logic [29:0] npc;
    logic        pc_wr;
    logic        redirect;
    logic [29:0] pc;
    logic        imem_req_valid;
    logic [29:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        id_stall;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [29:0] ifid_pc;
    logic        fetch_err;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_drop;
`endif

    int          errors = 0;
    int          checks = 0;
    bit          mem_auto;
    bit          npc_auto;
    int          mem_lat;
    int          mem_cnt;
    logic [29:0] mem_addr;

    if_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .npc            (npc),
        .pc_wr          (pc_wr),
        .redirect       (redirect),
        .pc             (pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .id_stall       (id_stall),
        .ifid_valid     (ifid_valid),
        .ifid_instr     (ifid_instr),
        .ifid_pc        (ifid_pc),
        .fetch_err      (fetch_err)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch     (perf_fetch),
        .perf_drop      (perf_drop)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish before 2ms");
        $fatal(1);
    end

    // One clock: remember what the DUT offered, cross the edge, then model memory and next-PC.
    task automatic step();
        logic        acc;
        logic [29:0] a;
        acc = imem_req_valid && imem_req_ready && !rst;
        a   = imem_req_addr;
        @(posedge clk);
        #1;
        if (mem_auto) begin
            imem_rsp_valid = 1'b0;
            if (acc) begin
                mem_cnt  = mem_lat;
                mem_addr = a;
            end
            if (mem_cnt > 0) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = {2'b00, mem_addr};
                end
            end
        end
        if (npc_auto) npc = pc + 30'd1;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect       = 1'b0;
        id_stall       = 1'b0;
        pc_wr          = 1'b1;
        imem_req_ready = 1'b1;
        mem_auto       = 1'b1;
        npc_auto       = 1'b1;
        mem_lat        = 1;
        step();
        step();
        rst            = 1'b0;
        mem_cnt        = 0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        npc            = pc + 30'd1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (pc !== 30'h0C00) begin errors++; $display("FAIL reset_pc got=%h exp=%h", pc, 30'h0C00); end
        checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL reset_req_valid got=%b exp=1", imem_req_valid); end
        checks++; if (imem_req_addr !== 30'h0C00) begin errors++; $display("FAIL reset_req_addr got=%h exp=%h", imem_req_addr, 30'h0C00); end
        checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL reset_ifid_valid got=%b exp=0", ifid_valid); end
        checks++; if (ifid_instr !== 32'h0) begin errors++; $display("FAIL reset_ifid_instr got=%h exp=0", ifid_instr); end
        checks++; if (ifid_pc !== 30'h0) begin errors++; $display("FAIL reset_ifid_pc got=%h exp=0", ifid_pc); end
        checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL reset_fetch_err got=%b exp=0", fetch_err); end
`ifdef IF_PERF_CNT_EN
        checks++; if (perf_fetch !== 32'd0 || perf_drop !== 32'd0) begin errors++; $display("FAIL reset_perf got=%0d/%0d exp=0/0", perf_fetch, perf_drop); end
`endif
    endtask

    task automatic test_stream();
        logic [29:0] exp_pc;
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            step();
            checks++; if (ifid_valid !== ((i % 2) == 0)) begin errors++; $display("FAIL stream_valid step=%0d got=%b exp=%b", i, ifid_valid, (i % 2) == 0); end
            if ((i % 2) == 0) begin
                exp_pc = 30'h0C00 + 30'(i / 2 - 1);
                checks++; if (ifid_pc !== exp_pc) begin errors++; $display("FAIL stream_pc step=%0d got=%h exp=%h", i, ifid_pc, exp_pc); end
                checks++; if (ifid_instr !== {2'b00, exp_pc}) begin errors++; $display("FAIL stream_instr step=%0d got=%h exp=%h", i, ifid_instr, {2'b00, exp_pc}); end
            end else begin
                checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL stream_wait_req step=%0d got=%b exp=0", i, imem_req_valid); end
            end
        end
`ifdef IF_PERF_CNT_EN
        checks++; if (perf_fetch !== 32'd3) begin errors++; $display("FAIL stream_perf_fetch got=%0d exp=3", perf_fetch); end
`endif
    endtask

    task automatic test_pc_hold();
        do_reset();
        pc_wr = 1'b0;
        step();
        step();
        checks++; if (pc !== 30'h0C00) begin errors++; $display("FAIL hold_pc got=%h exp=%h", pc, 30'h0C00); end
        checks++; if (ifid_pc !== 30'h0C00 || ifid_valid !== 1'b1) begin errors++; $display("FAIL hold_first got=%h/%b exp=%h/1", ifid_pc, ifid_valid, 30'h0C00); end
        step();
        step();
        checks++; if (ifid_pc !== 30'h0C00 || ifid_valid !== 1'b1) begin errors++; $display("FAIL hold_refetch got=%h/%b exp=%h/1", ifid_pc, ifid_valid, 30'h0C00); end
        pc_wr = 1'b1;
    endtask

    task automatic test_skid();
        do_reset();
        id_stall = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step();
            if (i >= 4) begin
                checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL skid_no_req step=%0d got=%b exp=0", i, imem_req_valid); end
                checks++; if (ifid_pc !== 30'h0C00 || ifid_valid !== 1'b1) begin errors++; $display("FAIL skid_ifid step=%0d got=%h/%b exp=%h/1", i, ifid_pc, ifid_valid, 30'h0C00); end
            end
        end
        id_stall = 1'b0;
        step();
        checks++; if (ifid_pc !== 30'h0C01 || ifid_instr !== 32'h0000_0C01 || ifid_valid !== 1'b1) begin errors++; $display("FAIL skid_release got=%h/%h/%b exp=%h/%h/1", ifid_pc, ifid_instr, ifid_valid, 30'h0C01, 32'h0000_0C01); end
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 30'h0C02) begin errors++; $display("FAIL skid_next_req got=%b/%h exp=1/%h", imem_req_valid, imem_req_addr, 30'h0C02); end
        step();
        checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL skid_consumed got=%b exp=0", ifid_valid); end
        step();
        checks++; if (ifid_pc !== 30'h0C02 || ifid_valid !== 1'b1) begin errors++; $display("FAIL skid_after got=%h/%b exp=%h/1", ifid_pc, ifid_valid, 30'h0C02); end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        mem_lat = 3;
        step();
        npc_auto = 1'b0;
        npc      = 30'h0D00;
        redirect = 1'b1;
        step();
        redirect = 1'b0;
        checks++; if (pc !== 30'h0D00 || imem_req_valid !== 1'b0) begin errors++; $display("FAIL rdw_pc got=%h/%b exp=%h/0", pc, imem_req_valid, 30'h0D00); end
        step();
        checks++; if (imem_rsp_valid !== 1'b1) begin errors++; $display("FAIL rdw_model_rsp got=%b exp=1", imem_rsp_valid); end
        mem_lat  = 1;
        npc_auto = 1'b1;
        step();
        checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL rdw_dropped got=%b exp=0", ifid_valid); end
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 30'h0D00) begin errors++; $display("FAIL rdw_next_req got=%b/%h exp=1/%h", imem_req_valid, imem_req_addr, 30'h0D00); end
`ifdef IF_PERF_CNT_EN
        checks++; if (perf_drop !== 32'd1) begin errors++; $display("FAIL rdw_perf_drop got=%0d exp=1", perf_drop); end
`endif
        step();
        step();
        checks++; if (ifid_pc !== 30'h0D00 || ifid_instr !== 32'h0000_0D00 || ifid_valid !== 1'b1) begin errors++; $display("FAIL rdw_target got=%h/%h/%b exp=%h/%h/1", ifid_pc, ifid_instr, ifid_valid, 30'h0D00, 32'h0000_0D00); end
    endtask

    task automatic test_redirect_accept();
        do_reset();
        for (int i = 1; i <= 10; i++) step();
        checks++; if (pc !== 30'h0C05 || imem_req_valid !== 1'b1) begin errors++; $display("FAIL rda_setup got=%h/%b exp=%h/1", pc, imem_req_valid, 30'h0C05); end
        npc_auto = 1'b0;
        npc      = 30'h0E00;
        redirect = 1'b1;
        step();
        redirect = 1'b0;
        checks++; if (pc !== 30'h0E00 || ifid_valid !== 1'b0 || imem_req_valid !== 1'b0) begin errors++; $display("FAIL rda_flush got=%h/%b/%b exp=%h/0/0", pc, ifid_valid, imem_req_valid, 30'h0E00); end
        npc_auto = 1'b1;
        npc      = pc + 30'd1;
        step();
        checks++; if (ifid_valid !== 1'b0 || imem_req_addr !== 30'h0E00 || imem_req_valid !== 1'b1) begin errors++; $display("FAIL rda_dropped got=%b/%h/%b exp=0/%h/1", ifid_valid, imem_req_addr, imem_req_valid, 30'h0E00); end
        step();
        step();
        checks++; if (ifid_pc !== 30'h0E00 || ifid_instr !== 32'h0000_0E00 || ifid_valid !== 1'b1) begin errors++; $display("FAIL rda_target got=%h/%h/%b exp=%h/%h/1", ifid_pc, ifid_instr, ifid_valid, 30'h0E00, 32'h0000_0E00); end
`ifdef IF_PERF_CNT_EN
        checks++; if (perf_fetch !== 32'd6 || perf_drop !== 32'd1) begin errors++; $display("FAIL rda_perf got=%0d/%0d exp=6/1", perf_fetch, perf_drop); end
`endif
    endtask

    task automatic test_timeout();
        do_reset();
        mem_auto       = 1'b0;
        imem_rsp_valid = 1'b0;
        for (int i = 1; i <= 64; i++) step();
        checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL tmo_early got=%b exp=0", fetch_err); end
        step();
        checks++; if (fetch_err !== 1'b1) begin errors++; $display("FAIL tmo_set got=%b exp=1", fetch_err); end
        for (int i = 0; i < 10; i++) step();
        checks++; if (fetch_err !== 1'b1 || imem_req_valid !== 1'b0) begin errors++; $display("FAIL tmo_sticky got=%b/%b exp=1/0", fetch_err, imem_req_valid); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (fetch_err !== 1'b0 || pc !== 30'h0C00) begin errors++; $display("FAIL tmo_clear got=%b/%h exp=0/%h", fetch_err, pc, 30'h0C00); end
    endtask

    task automatic test_reset_hold();
        do_reset();
        id_stall = 1'b1;
        for (int i = 1; i <= 4; i++) step();
        checks++; if (imem_req_valid !== 1'b0 || ifid_valid !== 1'b1) begin errors++; $display("FAIL rsth_setup got=%b/%b exp=0/1", imem_req_valid, ifid_valid); end
        rst = 1'b1;
        step();
        rst      = 1'b0;
        id_stall = 1'b0;
        checks++; if (ifid_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 30'h0C00) begin errors++; $display("FAIL rsth_state got=%b/%b/%h exp=0/1/%h", ifid_valid, imem_req_valid, imem_req_addr, 30'h0C00); end
        mem_auto       = 1'b0;
        mem_cnt        = 0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        step();
        imem_rsp_valid = 1'b0;
        checks++; if (ifid_valid !== 1'b0 || imem_req_valid !== 1'b1 || pc !== 30'h0C00) begin errors++; $display("FAIL rsth_stale got=%b/%b/%h exp=0/1/%h", ifid_valid, imem_req_valid, pc, 30'h0C00); end
        imem_req_ready = 1'b1;
        mem_auto       = 1'b1;
        step();
        step();
        checks++; if (ifid_instr !== 32'h0000_0C00 || ifid_pc !== 30'h0C00 || ifid_valid !== 1'b1) begin errors++; $display("FAIL rsth_fetch got=%h/%h/%b exp=%h/%h/1", ifid_instr, ifid_pc, ifid_valid, 32'h0000_0C00, 30'h0C00); end
    endtask

    initial begin
        rst            = 1'b1;
        npc            = 30'h0;
        pc_wr          = 1'b1;
        redirect       = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        id_stall       = 1'b0;
        mem_cnt        = 0;
        mem_addr       = 30'h0;
        test_reset();
        test_stream();
        test_pc_hold();
        test_skid();
        test_redirect_wait();
        test_redirect_accept();
        test_timeout();
        test_reset_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage for the pipelined MIPS core.
- Owns the PC register and issues word fetches to instruction memory over a valid/ready request and a pulsed response.
- Buffers returned instructions into the IF/ID register.
- Takes the next-PC value, advance enable and redirect from the next-PC/branch logic, and returns the current PC to it. This closes the PC -> next-PC -> PC loop.

Parameters:
- RESET_PC, 30'h0000_0C00, word address of the first fetch (byte address 0x0000_3000).
- RSP_TIMEOUT, 8'd64, cycles in S_WAIT before a fetch error is flagged.

Ports:
- clk  in  1  clock, all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- npc  in  30  next word address from next-PC logic, bits [31:2]
- pc_wr  in  1  advance enable; 0 = hold PC (stall)
- redirect  in  1  taken branch/jump/jr; npc carries the target; flushes IF/ID
- pc  out  30  current fetch PC [31:2]
- imem_req_valid  out  1  fetch request valid
- imem_req_addr  out  30  fetch word address
- imem_req_ready  in  1  memory accepts request
- imem_rsp_valid  in  1  one-cycle pulse, response data valid
- imem_rsp_data  in  32  fetched instruction
- id_stall  in  1  ID not consuming IF/ID this cycle
- ifid_valid  out  1  IF/ID holds a valid instruction
- ifid_instr  out  32  instruction to ID
- ifid_pc  out  30  PC of ifid_instr
- fetch_err  out  1  sticky; response timeout

Behaviour:
- Reset, synchronous, overriding all else, also mid-transaction:
  - pc=RESET_PC; state=S_REQ; drop=0; skid empty; fetch_err=0.
  - ifid_valid=0; ifid_instr=32'h0 (nop); ifid_pc=0; imem_req_valid=1 from the first post-reset cycle.
- imem_req_addr = pc, combinational.
- A request is accepted on the cycle where imem_req_valid && imem_req_ready. At most one fetch is outstanding.
- Consume: IF/ID is consumed in any cycle with ifid_valid && !id_stall. IF/ID can load when !ifid_valid or it is being consumed.
- States:
  - S_REQ: req_valid=1.
    - Accept -> S_WAIT.
    - Not accepted: address may change next cycle, which the memory port tolerates.
  - S_WAIT: req_valid=0; timeout counter runs.
    - On rsp_valid with drop=1: discard data, clear drop -> S_REQ.
    - Else if IF/ID can load: ifid <= {rsp_data, pc}; pc <= pc_wr ? npc : pc; -> S_REQ.
    - Else: capture into skid -> S_HOLD.
    - Counter reaching RSP_TIMEOUT sets fetch_err. The state stays in S_WAIT until a response or reset.
  - S_HOLD: req_valid=0. When IF/ID can load: ifid <= skid; pc update as above -> S_REQ.
- Redirect takes priority over the load:
  - pc <= npc; ifid_valid <= 0; skid cleared; state -> S_REQ.
  - If a fetch is outstanding (S_WAIT), or accepted this same cycle, set drop=1 and stay in/enter S_WAIT to swallow that response.
- Redirect and response in the same S_WAIT cycle: the response is discarded, drop stays 0 -> S_REQ with the target.
- pc_wr=0 at load time: the instruction is still delivered and pc is unchanged, so the same address is refetched. Next-PC logic outputs pc when stalled.
- PC arithmetic is done upstream. The pc register wraps naturally at 30 bits.
- Throughput: one instruction per 2 cycles minimum with single-cycle memory. Fetch latency is request-accept to IF/ID valid = response cycle + 1.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- Defined: adds outputs perf_fetch (32-bit count of instructions loaded into IF/ID) and perf_drop (32-bit count of discarded responses). Both reset to 0, wrap at 2^32, and count at most 1 per cycle.
- Undefined: neither the ports nor the counters exist. All other behaviour is identical.

Test Plan:
- Reset then zero-wait memory returning addr as data, id_stall=0, pc_wr=1, npc=pc+1 -> first req addr 0x0C00; ifid sequence (0x0C00,0x0C01,0x0C02); ifid_pc matches; one instruction every 2 cycles.
- id_stall=1 for 5 cycles with IF/ID full while a response arrives -> skid holds it, state S_HOLD, no new request; after release the instructions arrive in order with none lost or duplicated.
- redirect with npc=0x0D00 while in S_WAIT, response returns 3 cycles later -> response dropped; ifid_valid=0; next req addr 0x0D00; perf_drop=1 (with macro).
- redirect coincident with request accept at 0x0C05 -> the 0x0C05 data never reaches IF/ID; next delivered ifid_pc = target.
- No response for 64 cycles -> fetch_err=1 and sticky; rst pulse clears it; pc=0x0C00.
- rst asserted in S_HOLD -> next cycle ifid_valid=0, req_valid=1, addr 0x0C00; a stale response after reset is ignored because the fetch is in S_REQ.
